// File: rtl/fetch_decode_if.sv
// Instruction-memory fetch port: request/address out, ack/data back.
// The requester holds addr stable while req is high; ack qualifies rdata.
interface fetch_decode_if;
  logic        req;
  logic [15:0] addr;
  logic        ack;
  logic [15:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode stage: owns the PC, fetches one instruction and issues it for one cycle.
// Latency: ISSUE follows the ack edge; the memory stalls the stage by withholding ack.
module fetch_decode #(
  parameter logic [15:0] BUBBLE = 16'h6000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_run,
  input  logic [15:0]    i_next_pc,
  fetch_decode_if.master imem,
  input  logic [15:0]    i_reg0,
  input  logic [15:0]    i_reg1,
  input  logic [15:0]    i_reg2,
  input  logic [15:0]    i_reg3,
  input  logic [15:0]    i_reg4,
  input  logic [15:0]    i_reg5,
  input  logic [15:0]    i_reg6,
  input  logic [15:0]    i_reg7,
  output logic [15:0]    o_pc,
  output logic [15:0]    o_instr,
  output logic [15:0]    o_ra,
  output logic [15:0]    o_rb,
  output logic [15:0]    o_rc,
  output logic [6:0]     o_imm7,
  output logic [9:0]     o_imm10,
  output logic           o_issue,
  output logic [15:0]    o_instr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_count;
  logic        w_req;
  logic        w_issue;
  logic [15:0] w_instr;
  logic [15:0] w_regs [8];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= 16'h0000;
      r_ir    <= BUBBLE;
      r_count <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FETCH && imem.ack) begin
        r_ir <= imem.rdata;
      end
      // The ALU writes its registers on this same edge, so next_pc is final here.
      if (r_state == S_ISSUE) begin
        r_pc    <= i_next_pc;
        r_count <= r_count + 16'h0001;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (imem.ack) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        w_issue      = 1'b1;
        w_next_state = i_run ? S_FETCH : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_regs[0] = i_reg0;
  assign w_regs[1] = i_reg1;
  assign w_regs[2] = i_reg2;
  assign w_regs[3] = i_reg3;
  assign w_regs[4] = i_reg4;
  assign w_regs[5] = i_reg5;
  assign w_regs[6] = i_reg6;
  assign w_regs[7] = i_reg7;

  assign w_instr   = w_issue ? r_ir : BUBBLE;

  assign imem.req  = w_req;
  assign imem.addr = {2'b00, r_pc[13:0]};

  assign o_pc          = r_pc;
  assign o_instr       = w_instr;
  assign o_issue       = w_issue;
  assign o_instr_count = r_count;
  assign o_ra          = w_regs[w_instr[12:10]];
  assign o_rb          = w_regs[w_instr[9:7]];
  assign o_rc          = w_regs[w_instr[2:0]];
  assign o_imm7        = w_instr[6:0];
  assign o_imm10       = w_instr[9:0];

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed cycle table, then randomized fetch transactions
// checked against a transaction-level model of PC, count and issued instruction.
module tb_fetch_decode;
  localparam logic [15:0] BUB = 16'h6000;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] next_pc;
  logic [15:0] regs [8];
  logic [15:0] pc, instr, ra, rb, rc, instr_count;
  logic [6:0]  imm7;
  logic [9:0]  imm10;
  logic        issue;

  int n_vec = 0;
  int n_bad = 0;

  fetch_decode_if imem_if ();

  fetch_decode #(.BUBBLE(BUB)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_next_pc(next_pc), .imem(imem_if),
    .i_reg0(regs[0]), .i_reg1(regs[1]), .i_reg2(regs[2]), .i_reg3(regs[3]),
    .i_reg4(regs[4]), .i_reg5(regs[5]), .i_reg6(regs[6]), .i_reg7(regs[7]),
    .o_pc(pc), .o_instr(instr), .o_ra(ra), .o_rb(rb), .o_rc(rc),
    .o_imm7(imm7), .o_imm10(imm10), .o_issue(issue), .o_instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, run, ack;
    logic [15:0] rdata, npc;
    logic        exp_req, exp_issue;
    logic [15:0] exp_addr, exp_instr, exp_pc, exp_cnt;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(logic r, logic rn, logic a, logic [15:0] rd, logic [15:0] np,
                              logic eq, logic ei, logic [15:0] ea, logic [15:0] ein,
                              logic [15:0] ep, logic [15:0] ec);
    vec_t v;
    v.rst = r; v.run = rn; v.ack = a; v.rdata = rd; v.npc = np;
    v.exp_req = eq; v.exp_issue = ei; v.exp_addr = ea; v.exp_instr = ein;
    v.exp_pc = ep; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decode fields follow directly from the instruction word the stage should be showing.
  task automatic check_all(input string tag, input logic e_req, input logic e_issue,
                           input logic [15:0] e_addr, input logic [15:0] e_instr,
                           input logic [15:0] e_pc, input logic [15:0] e_cnt);
    chk({tag, " req"},   {15'b0, imem_if.req}, {15'b0, e_req});
    chk({tag, " issue"}, {15'b0, issue},       {15'b0, e_issue});
    chk({tag, " addr"},  imem_if.addr, e_addr);
    chk({tag, " instr"}, instr, e_instr);
    chk({tag, " pc"},    pc, e_pc);
    chk({tag, " count"}, instr_count, e_cnt);
    chk({tag, " ra"},    ra, regs[e_instr[12:10]]);
    chk({tag, " rb"},    rb, regs[e_instr[9:7]]);
    chk({tag, " rc"},    rc, regs[e_instr[2:0]]);
    chk({tag, " imm7"},  {9'b0, imm7}, {9'b0, e_instr[6:0]});
    chk({tag, " imm10"}, {6'b0, imm10}, {6'b0, e_instr[9:0]});
  endtask

  task automatic drive(input logic r, input logic rn, input logic a,
                       input logic [15:0] rd, input logic [15:0] np);
    @(posedge clk);
    #1;
    rst = r; run = rn; imem_if.ack = a; imem_if.rdata = rd; next_pc = np;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] m_pc;
    logic [15:0] m_cnt;

    rst = 1'b1; run = 1'b0; next_pc = 16'h0;
    imem_if.ack = 1'b0; imem_if.rdata = 16'h0;
    regs[0] = 16'h1111; regs[1] = 16'h2222; regs[2] = 16'h3333; regs[3] = 16'hAAAA;
    regs[4] = 16'h4444; regs[5] = 16'h5555; regs[6] = 16'h6666; regs[7] = 16'h7777;

    //              rst run ack rdata     npc       req iss addr      instr     pc        cnt
    tbl[0]  = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, BUB,      16'h0000, 16'd0);
    tbl[1]  = mk(0, 1, 1, 16'h2481, 16'h0000, 1, 0, 16'h0000, BUB,      16'h0000, 16'd0);
    tbl[2]  = mk(0, 1, 0, 16'h0000, 16'h0001, 0, 1, 16'h0000, 16'h2481, 16'h0000, 16'd0);
    tbl[3]  = mk(0, 1, 1, 16'h0000, 16'h0000, 1, 0, 16'h0001, BUB,      16'h0001, 16'd1);
    tbl[4]  = mk(0, 1, 0, 16'h0000, 16'h0002, 0, 1, 16'h0001, 16'h0000, 16'h0001, 16'd1);
    tbl[5]  = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002, BUB,      16'h0002, 16'd2);
    tbl[6]  = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002, BUB,      16'h0002, 16'd2);
    tbl[7]  = mk(0, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0002, BUB,      16'h0002, 16'd2);
    tbl[8]  = mk(0, 1, 1, 16'h1D85, 16'h0000, 1, 0, 16'h0002, BUB,      16'h0002, 16'd2);
    tbl[9]  = mk(0, 1, 0, 16'h0000, 16'h0040, 0, 1, 16'h0002, 16'h1D85, 16'h0002, 16'd2);
    tbl[10] = mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, BUB,      16'h0040, 16'd3);
    tbl[11] = mk(0, 0, 1, 16'h2481, 16'h0000, 1, 0, 16'h0040, BUB,      16'h0040, 16'd3);
    tbl[12] = mk(0, 0, 0, 16'h0000, 16'hC012, 0, 1, 16'h0040, 16'h2481, 16'h0040, 16'd3);
    tbl[13] = mk(0, 0, 1, 16'hFFFF, 16'h0000, 0, 0, 16'h0012, BUB,      16'hC012, 16'd4);
    tbl[14] = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 16'h0012, BUB,      16'hC012, 16'd4);
    tbl[15] = mk(0, 1, 1, 16'h1234, 16'h0000, 1, 0, 16'h0012, BUB,      16'hC012, 16'd4);
    tbl[16] = mk(0, 1, 0, 16'h0000, 16'hFFFF, 0, 1, 16'h0012, 16'h1234, 16'hC012, 16'd4);
    tbl[17] = mk(0, 1, 1, 16'h0001, 16'h0000, 1, 0, 16'h3FFF, BUB,      16'hFFFF, 16'd5);
    tbl[18] = mk(0, 1, 0, 16'h0000, 16'h0000, 0, 1, 16'h3FFF, 16'h0001, 16'hFFFF, 16'd5);
    tbl[19] = mk(1, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, BUB,      16'h0000, 16'd6);
    tbl[20] = mk(0, 1, 1, 16'hBEEF, 16'h0000, 0, 0, 16'h0000, BUB,      16'h0000, 16'd0);
    tbl[21] = mk(0, 1, 1, 16'h3333, 16'h0000, 1, 0, 16'h0000, BUB,      16'h0000, 16'd0);
    tbl[22] = mk(1, 1, 0, 16'h0000, 16'h0099, 0, 1, 16'h0000, 16'h3333, 16'h0000, 16'd0);
    tbl[23] = mk(0, 0, 1, 16'hBEEF, 16'h0000, 0, 0, 16'h0000, BUB,      16'h0000, 16'd0);
    tbl[24] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, BUB,      16'h0000, 16'd0);

    drive(1, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 0, 16'h0, 16'h0);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].run, tbl[i].ack, tbl[i].rdata, tbl[i].npc);
      check_all($sformatf("row%0d", i), tbl[i].exp_req, tbl[i].exp_issue, tbl[i].exp_addr,
                tbl[i].exp_instr, tbl[i].exp_pc, tbl[i].exp_cnt);
    end

    // Randomized transactions: each fetch waits lat cycles for ack, then issues once.
    drive(1, 0, 0, 16'h0, 16'h0);
    drive(0, 1, 0, 16'h0, 16'h0);
    m_pc  = 16'h0000;
    m_cnt = 16'h0000;
    for (int t = 0; t < 200; t++) begin
      int          lat;
      logic [15:0] ins;
      logic [15:0] np;
      lat = int'($urandom_range(0, 3));
      ins = 16'($urandom());
      np  = 16'($urandom());
      for (int k = 0; k < 8; k++) regs[k] = 16'($urandom());
      for (int c = 0; c <= lat; c++) begin
        drive(0, 1, (c == lat), (c == lat) ? ins : 16'($urandom()), 16'($urandom()));
        check_all($sformatf("rnd%0d fetch%0d", t, c), 1'b1, 1'b0,
                  {2'b00, m_pc[13:0]}, BUB, m_pc, m_cnt);
      end
      drive(0, 1, 1'($urandom()), 16'($urandom()), np);
      check_all($sformatf("rnd%0d issue", t), 1'b0, 1'b1, {2'b00, m_pc[13:0]}, ins, m_pc, m_cnt);
      m_pc  = np;
      m_cnt = m_cnt + 16'h0001;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
